// File: rtl/registradores_param.sv
// Parametrised register file with hard-wired zero, write bypass and
// a pending-write scoreboard for load-use hazard detection.
module registradores_param #(
    parameter int LARGURA       = 32,
    parameter int BITS_ENDERECO = 5,
    parameter int ZERO_FIXO     = 1,
    parameter int BYPASS        = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [BITS_ENDERECO-1:0] endereco_L1,
    input  logic [BITS_ENDERECO-1:0] endereco_L2,
    input  logic [BITS_ENDERECO-1:0] endereco_E,
    input  logic [LARGURA-1:0]       dados,
    input  logic                     escreve_R,
    input  logic                     reserva_R,
    input  logic [BITS_ENDERECO-1:0] endereco_reserva,
    output logic [LARGURA-1:0]       resultado_RS,
    output logic [LARGURA-1:0]       resultado_RT,
    output logic [LARGURA-1:0]       resultado_RD,
    output logic                     ocupado_RS,
    output logic                     ocupado_RT,
    output logic [BITS_ENDERECO:0]   pendentes
);

    localparam int N = 2 ** BITS_ENDERECO;
    localparam logic [BITS_ENDERECO:0] UM = 1;

    typedef logic [BITS_ENDERECO-1:0] addr_t;

    logic [LARGURA-1:0]     banco [N];
    logic [N-1:0]           busy;
    logic [N-1:0]           busy_next;
    logic [BITS_ENDERECO:0] conta;
    logic                   escrita_ok;
    logic                   reserva_ok;
    logic                   regrava;
    logic                   liberado;
    logic                   incrementa;
    logic                   decrementa;
    addr_t                  enderecos [3];
    logic [LARGURA-1:0]     leituras [3];
    logic                   ocupados [2];

    function automatic logic gravavel(input addr_t a);
        return (ZERO_FIXO == 0) || (a != '0);
    endfunction

    assign escrita_ok = escreve_R && gravavel(endereco_E);
    assign reserva_ok = reserva_R && gravavel(endereco_reserva);
    assign regrava    = reserva_ok && (endereco_reserva == endereco_E);
    assign liberado   = (BYPASS != 0) && escrita_ok && !regrava;

    // Reservation is applied after the write-back clear, so it wins on a tie.
    always_comb begin
        busy_next = busy;
        if (escrita_ok) busy_next[endereco_E] = 1'b0;
        if (reserva_ok) busy_next[endereco_reserva] = 1'b1;
    end

    assign incrementa = reserva_ok && !busy[endereco_reserva];
    assign decrementa = escrita_ok && busy[endereco_E] && !regrava;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy  <= '0;
            conta <= '0;
        end else begin
            busy <= busy_next;
            if (incrementa && !decrementa)
                conta <= conta + UM;
            else if (decrementa && !incrementa)
                conta <= conta - UM;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                banco[i] <= '0;
        end else if (escrita_ok) begin
            banco[endereco_E] <= dados;
        end
    end

    assign enderecos[0] = endereco_L1;
    assign enderecos[1] = endereco_L2;
    assign enderecos[2] = endereco_E;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            leituras[k] = banco[enderecos[k]];
            if ((BYPASS != 0) && escrita_ok && (enderecos[k] == endereco_E))
                leituras[k] = dados;
            if ((ZERO_FIXO != 0) && (enderecos[k] == '0))
                leituras[k] = '0;
        end
    end

    // A write retiring this cycle hides the busy flag unless re-reserved.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ocupados[k] = busy[enderecos[k]];
            if (liberado && (enderecos[k] == endereco_E))
                ocupados[k] = 1'b0;
            if ((ZERO_FIXO != 0) && (enderecos[k] == '0))
                ocupados[k] = 1'b0;
        end
    end

    assign resultado_RS = leituras[0];
    assign resultado_RT = leituras[1];
    assign resultado_RD = leituras[2];
    assign ocupado_RS   = ocupados[0];
    assign ocupado_RT   = ocupados[1];
    assign pendentes    = conta;

endmodule
